// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : fb_pixel_writer
// Brief    : Buffers pixel strobes in a small FIFO and writes them, or full
//            frame clears, to a granted framebuffer memory port.
// Revision : 1.0
// ============================================================================
module fb_pixel_writer #(
    parameter int         FB_W_LOG2 = 8,
    parameter int         FB_H      = 256,
    parameter int         MEM_AW    = 16,
    parameter int         FIFO_LOG2 = 3,
    parameter logic [7:0] PIX_COLOR = 8'hFF,
    parameter logic [7:0] BG_COLOR  = 8'h00
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [15:0]       xAddr,
    input  logic [15:0]       yAddr,
    input  logic              Write,
    input  logic              clear_req,
    input  logic              mem_grant,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              fifo_full,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int c_DEPTH = 1 << FIFO_LOG2;
    localparam int c_CW    = FIFO_LOG2 + 1;
    localparam logic [MEM_AW-1:0] c_LAST = MEM_AW'((FB_H << FB_W_LOG2) - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_CLEAR = 2'd2;

    logic [1:0]           r_state;
    logic                 r_in_vld;
    logic [15:0]          r_in_x;
    logic [15:0]          r_in_y;
    logic [MEM_AW-1:0]    r_ram [c_DEPTH];
    logic [FIFO_LOG2-1:0] r_wr;
    logic [FIFO_LOG2-1:0] r_rd;
    logic [c_CW-1:0]      r_count;
    logic                 r_clear_pend;
    logic [7:0]           r_drop;
    logic [MEM_AW-1:0]    r_mem_addr;
    logic [7:0]           r_mem_wdata;
    logic                 r_mem_we;

    logic                 w_in_range;
    logic [MEM_AW-1:0]    w_pix_addr;
    logic                 w_full;
    logic                 w_granted_pix;
    logic [c_CW-1:0]      w_avail;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_load;
    logic                 w_clr_done;
    logic                 w_clr_start;

    assign w_in_range = (32'(r_in_x) < 32'(1 << FB_W_LOG2)) && (32'(r_in_y) < 32'(FB_H));
    assign w_pix_addr = (MEM_AW'(r_in_y) << FB_W_LOG2) | MEM_AW'(r_in_x);

    // r_count holds every accepted pixel not yet granted, including the word
    // sitting in the output registers; w_avail excludes that word.
    assign w_full        = (r_count == c_CW'(c_DEPTH));
    assign w_granted_pix = (r_state == c_ST_DRAIN) && mem_grant;
    assign w_avail       = r_count - c_CW'(r_state == c_ST_DRAIN);
    assign w_push        = r_in_vld && w_in_range && (!w_full || w_granted_pix);
    assign w_drop        = r_in_vld && !w_push;
    assign w_load        = ((r_state == c_ST_IDLE) || w_granted_pix) && (w_avail != '0);
    assign w_clr_done    = (r_state == c_ST_CLEAR) && mem_grant && (r_mem_addr == c_LAST);
    assign w_clr_start   = (r_state == c_ST_IDLE) && r_clear_pend && (r_count == '0) && !r_in_vld;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_in_vld <= 1'b0;
            r_in_x   <= '0;
            r_in_y   <= '0;
        end else begin
            r_in_vld <= Write;
            r_in_x   <= xAddr;
            r_in_y   <= yAddr;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_ram[r_wr] <= w_pix_addr;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_load) begin
                r_rd <= r_rd + 1'b1;
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_granted_pix);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    // Completion clears the request even if a new one lands that cycle.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_clear_pend <= 1'b0;
        end else if (w_clr_done) begin
            r_clear_pend <= 1'b0;
        end else if (clear_req) begin
            r_clear_pend <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= c_ST_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_load) begin
                        r_mem_addr  <= r_ram[r_rd];
                        r_mem_wdata <= PIX_COLOR;
                        r_mem_we    <= 1'b1;
                        r_state     <= c_ST_DRAIN;
                    end else if (w_clr_start) begin
                        r_mem_addr  <= '0;
                        r_mem_wdata <= BG_COLOR;
                        r_mem_we    <= 1'b1;
                        r_state     <= c_ST_CLEAR;
                    end
                end
                c_ST_DRAIN: begin
                    if (mem_grant) begin
                        if (w_load) begin
                            r_mem_addr  <= r_ram[r_rd];
                            r_mem_wdata <= PIX_COLOR;
                        end else begin
                            r_mem_we <= 1'b0;
                            r_state  <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_CLEAR: begin
                    if (mem_grant) begin
                        if (w_clr_done) begin
                            r_mem_we <= 1'b0;
                            r_state  <= c_ST_IDLE;
                        end else begin
                            r_mem_addr <= r_mem_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign fifo_full = w_full;
    assign drop_cnt  = r_drop;
    assign busy      = (r_state != c_ST_IDLE) || (r_count != '0) || r_clear_pend || r_in_vld;

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_pixel_writer
// Brief    : Directed scoreboard bench for fb_pixel_writer.
// Revision : 1.0
// ============================================================================
module tb_fb_pixel_writer;

    logic        ACLK;
    logic        ARESETn;
    logic [15:0] xAddr;
    logic [15:0] yAddr;
    logic        Write;
    logic        clear_req;
    logic        mem_grant;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        fifo_full;
    logic        busy;
    logic [7:0]  drop_cnt;

    int          errs   = 0;
    int          checks = 0;
    logic [23:0] exp_q[$];

    fb_pixel_writer dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .xAddr     (xAddr),
        .yAddr     (yAddr),
        .Write     (Write),
        .clear_req (clear_req),
        .mem_grant (mem_grant),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .fifo_full (fifo_full),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pa(input int x, input int y);
        return 16'((y << 8) | x);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    // One-cycle pixel strobe; in-range pixels are expected on the port later.
    task automatic pix(input int x, input int y);
        Write = 1'b1;
        xAddr = 16'(x);
        yAddr = 16'(y);
        if (x < 256 && y < 256) exp_q.push_back({pa(x, y), 8'hFF});
        cyc(1);
        Write = 1'b0;
    endtask

    // A transfer happens at the posedge following a cycle with mem_we & mem_grant.
    always @(negedge ACLK) begin
        #2;
        if (ARESETn && mem_we === 1'b1 && mem_grant === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("write_with_empty_scoreboard", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("mem_write", {8'h0, mem_addr, mem_wdata}, {8'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int n;
        ARESETn   = 1'b0;
        xAddr     = '0;
        yAddr     = '0;
        Write     = 1'b0;
        clear_req = 1'b0;
        mem_grant = 1'b0;
        cyc(3);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        ARESETn = 1'b1;
        cyc(2);

        // Single pixel latency
        mem_grant = 1'b1;
        pix(3, 2);
        cyc(1);
        chk("lat_we_early", 32'(mem_we), 32'd0);
        cyc(1);
        chk("lat_we", 32'(mem_we), 32'd1);
        chk("lat_addr", 32'(mem_addr), 32'h0203);
        chk("lat_data", 32'(mem_wdata), 32'hFF);
        cyc(1);
        chk("lat_one_cycle", 32'(mem_we), 32'd0);
        chk("lat_busy", 32'(busy), 32'd0);

        // Hold under grant low
        mem_grant = 1'b0;
        pix(10, 20);
        cyc(2);
        for (int i = 0; i < 5; i++) begin
            chk("hold_we", 32'(mem_we), 32'd1);
            chk("hold_addr", 32'(mem_addr), 32'h140A);
            chk("hold_data", 32'(mem_wdata), 32'hFF);
            cyc(1);
        end
        mem_grant = 1'b1;
        cyc(1);
        mem_grant = 1'b0;
        chk("hold_released", 32'(mem_we), 32'd0);
        chk("hold_sb_empty", 32'(exp_q.size()), 32'd0);

        // Overflow: 10 strobes, 8 accepted
        for (int i = 0; i < 10; i++) begin
            Write = 1'b1;
            xAddr = 16'(i);
            yAddr = 16'd5;
            if (i < 8) exp_q.push_back({pa(i, 5), 8'hFF});
            cyc(1);
        end
        Write = 1'b0;
        cyc(2);
        chk("ovf_full", 32'(fifo_full), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        mem_grant = 1'b1;
        n = 0;
        while (busy && n < 50) begin
            cyc(1);
            n++;
        end
        chk("ovf_drained", 32'(busy), 32'd0);
        chk("ovf_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("ovf_not_full", 32'(fifo_full), 32'd0);

        // Range drops and saturation
        pix(256, 0);
        pix(0, 256);
        cyc(3);
        chk("range_drop", 32'(drop_cnt), 32'd4);
        Write = 1'b1;
        xAddr = 16'd300;
        yAddr = 16'd0;
        cyc(300);
        Write = 1'b0;
        cyc(2);
        chk("drop_sat", 32'(drop_cnt), 32'hFF);
        pix(255, 255);
        cyc(5);
        chk("corner_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("drop_sat_hold", 32'(drop_cnt), 32'hFF);

        // Clear behind two queued pixels; extra requests are absorbed
        mem_grant = 1'b0;
        pix(1, 1);
        pix(2, 3);
        cyc(2);
        clear_req = 1'b1;
        cyc(1);
        clear_req = 1'b0;
        for (int a = 0; a < 65536; a++) exp_q.push_back({16'(a), 8'h00});
        cyc(2);
        clear_req = 1'b1;
        cyc(1);
        clear_req = 1'b0;
        chk("clr_busy", 32'(busy), 32'd1);
        mem_grant = 1'b1;
        cyc(100);
        clear_req = 1'b1;
        cyc(1);
        clear_req = 1'b0;
        n = 0;
        while (busy && n < 70000) begin
            cyc(1);
            n++;
        end
        chk("clr_done", 32'(busy), 32'd0);
        cyc(5);
        chk("clr_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("clr_idle_we", 32'(mem_we), 32'd0);

        // Reset in the middle of a clear
        clear_req = 1'b1;
        cyc(1);
        clear_req = 1'b0;
        for (int a = 0; a < 65536; a++) exp_q.push_back({16'(a), 8'h00});
        n = 0;
        while (n < 300) begin
            @(negedge ACLK);
            if (mem_we === 1'b1 && mem_addr == 16'd100) break;
            n++;
        end
        chk("rst_mid_reached", 32'(n < 300), 32'd1);
        mem_grant = 1'b0;
        ARESETn   = 1'b0;
        #1;
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_progress", 32'(exp_q.size()), 32'(65536 - 100));
        exp_q.delete();
        cyc(2);
        ARESETn   = 1'b1;
        mem_grant = 1'b1;
        cyc(20);
        chk("rst_mid_after_we", 32'(mem_we), 32'd0);
        chk("rst_mid_after_busy", 32'(busy), 32'd0);
        chk("rst_mid_drop", 32'(drop_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
